// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide execute unit
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            neg_a, neg_b;
  // hi/lo hold the running product for multiply, remainder/quotient for divide
  logic [XLEN-1:0] hi, lo;

  logic            accept, in_div, sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic            div_zero, ovf, fast;
  logic [XLEN-1:0] in_mag_a, in_mag_b, fast_res;

  assign accept   = start_i && !kill_i && (state == IDLE || state == DONE);
  assign in_div   = funct3_i[2];
  assign sgn_b    = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign sgn_a    = sgn_b || (funct3_i == 3'b010);
  assign in_neg_a = sgn_a && op_a_i[XLEN-1];
  assign in_neg_b = sgn_b && op_b_i[XLEN-1];
  assign in_mag_a = in_neg_a ? -op_a_i : op_a_i;
  assign in_mag_b = in_neg_b ? -op_b_i : op_b_i;

  assign div_zero = in_div && (op_b_i == '0);
  assign ovf      = in_div && !funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (op_b_i == '1);
  assign fast     = div_zero || ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = funct3_i[1] ? op_a_i : '1;
    end else if (ovf) begin
      // op_a_i is the most negative value here, which is also the DIV answer
      fast_res = funct3_i[1] ? '0 : op_a_i;
    end
  end

  logic [XLEN:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
  assign div_shift = {hi, lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;
  assign prod    = {hi, lo};
  assign prod_s  = (neg_a ^ neg_b) ? -prod : prod;
  assign quo_s   = (neg_a ^ neg_b) ? -lo : lo;
  assign rem_s   = neg_a ? -hi : hi;
  assign fix_res = funct3_q[2] ? (funct3_q[1] ? rem_s : quo_s)
                 : ((funct3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done_o    = (state == DONE);
        state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        busy_o    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill_i) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else if (!kill_i) begin
      if (accept) begin
        funct3_q <= funct3_i;
        rd_q     <= rd_i;
        cnt      <= CW'(XLEN);
        mag_a    <= in_mag_a;
        mag_b    <= in_mag_b;
        neg_a    <= in_neg_a;
        neg_b    <= in_neg_b;
        hi       <= '0;
        lo       <= in_div ? in_mag_a : in_mag_b;
        if (fast) begin
          result_o <= fast_res;
          rd_o     <= rd_i;
        end
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        if (funct3_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi <= div_diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= div_shift[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
          end
        end else begin
          hi <= mul_sum[XLEN:1];
          lo <= {mul_sum[0], lo[XLEN-1:1]};
        end
      end else if (state == FIX) begin
        result_o <= fix_res;
        rd_o     <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic [4:0]  rd_i = '0;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          at;
  } exp_t;
  exp_t sb[$];

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .kill_i(kill_i),
    .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (rst) begin
      last_res = '0;
    end else if (done_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_o=1 result=%h want no done (cycle %0d)", result_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
        chk("done_cycle", cyc, e.at);
      end
      last_res = result_o;
    end else begin
      chk("result_hold", result_o, last_res);
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat, input bit track);
    exp_t e;
    funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd; start_i = 1'b1;
    if (track) begin
      e.res = res; e.rd = rd; e.at = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start_i  = 1'b0;
    funct3_i = 3'($urandom);
    op_a_i   = $urandom;
    op_b_i   = $urandom;
    rd_i     = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results want 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res, input int lat);
    issue(f3, a, b, rd, res, lat, 1'b1);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_rd", {27'd0, rd_o}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 34);
    run(3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 34);
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF, 34);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 34);
    run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 34);
    run(3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 34);
    run(3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       34);
    run(3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        34);
    run(3'b100, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 34);
    run(3'b110, 32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        34);
    run(3'b101, 32'hFFFFFFFF, 32'd1,        5'd13, 32'hFFFFFFFF, 34);
    run(3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
    run(3'b110, 32'd5,        32'd0,        5'd15, 32'd5,        1);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1);

    // kill in cycle 10 of a divide, restart in cycle 11
    issue(3'b101, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_busy", {31'd0, busy_o}, 32'd0);
    chk("kill_result", result_o, 32'd0);
    issue(3'b101, 32'd1000, 32'd3, 5'd21, 32'd333, 34, 1'b1);
    drain();

    // start pulses while busy are ignored
    issue(3'b111, 32'd1000, 32'd3, 5'd22, 32'd1, 34, 1'b1);
    repeat (4) @(negedge clk);
    funct3_i = 3'b000; op_a_i = 32'd9; op_b_i = 32'd9; rd_i = 5'd30; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    funct3_i = 3'b101; op_a_i = 32'd8; op_b_i = 32'd0; rd_i = 5'd31; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    drain();

    // back-to-back issue in the DONE cycle
    issue(3'b011, 32'h00010000, 32'h00010000, 5'd23, 32'd1, 34, 1'b1);
    repeat (33) @(negedge clk);
    chk("b2b_done_seen", {31'd0, done_o}, 32'd1);
    issue(3'b000, 32'd6, 32'd7, 5'd24, 32'd42, 34, 1'b1);
    drain();

    // reset mid-CALC clears every output
    issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd25, 32'd0, 0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(3'b000, 32'h0000FFFF, 32'h0000FFFF, 5'd26, 32'hFFFE0001, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Multi-cycle RV32M execute unit, directly downstream of instruction decode. Decode issues an R-type instruction with funct7 = 0000001 and passes the M-type funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) plus operands. The unit performs iterative shift-add multiply or restoring divide. It returns a 32-bit result with the destination register tag to the writeback path.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
start_i  in  1  issue request; accepted only in IDLE or DONE
kill_i  in  1  pipeline flush; aborts any in-flight operation
funct3_i  in  3  M-type funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a_i  in  XLEN  rs1 value (multiplicand/dividend)
op_b_i  in  XLEN  rs2 value (multiplier/divisor)
rd_i  in  5  destination register index
busy_o  out  1  high in CALC and FIX
done_o  out  1  one-cycle pulse, result valid
result_o  out  XLEN  result; held stable until next done_o
rd_o  out  5  rd captured at accept; held with result_o

Behaviour:
- Reset: state=IDLE, busy_o=0, done_o=0, result_o=0, rd_o=0, all internal registers 0. A reset during any state aborts the operation with no done_o.
- States: IDLE, CALC, FIX, DONE.
- Accept: start_i=1 && kill_i=0 in IDLE or DONE. On accept, latch funct3, rd, and operand magnitudes and signs, then go to CALC. The counter loads XLEN.
- Signedness: MULH treats a and b as signed; MULHSU treats a signed, b unsigned; DIV/REM treat both signed. MULHU/DIVU/REMU treat both unsigned. MUL is sign-independent (low 32 bits).
- CALC: one iteration per cycle for exactly 32 cycles on unsigned magnitudes.
  - Multiply: 64-bit shift-add.
  - Divide: restoring, 1 quotient bit per cycle.
  - Counter decrements; at 0 go to FIX.
- FIX (1 cycle): apply sign correction and select the output.
  - Product is negated if the operand signs differ.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
  - Quotient is negated if the signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Register result_o and rd_o, then go to DONE.
- DONE (1 cycle): done_o=1, busy_o=0. Go to CALC if a new start is accepted, else IDLE.
- Latency: start accepted in cycle 0 gives CALC in cycles 1–32, FIX in cycle 33, done_o in cycle 34. Back-to-back issue gives one result per 34 cycles.
- Fast path (accept goes directly to DONE, done_o in cycle 1):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- start_i while busy_o=1 is ignored; operands are not re-sampled.
- kill_i=1 in any state: next state IDLE. done_o is not asserted for the killed op and result_o is unchanged. kill_i has priority over start_i in the same cycle.
- Operand inputs need only be valid in the accept cycle.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3) -> done_o in cycle 34, result_o=0xFFFFFFEB, rd_o=rd_i.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each done_o in cycle 34.
- DIVU 5/0 -> 0xFFFFFFFF with done_o in cycle 1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM same operands -> 0.
- kill_i at cycle 10 of a DIV -> IDLE, no done_o, result_o keeps its prior value. A new start at cycle 11 completes normally in cycle 45.
- start_i pulsed at cycles 5 and 20 during a busy op -> ignored. Back-to-back start in the DONE cycle -> second done_o exactly 34 cycles later. rst asserted mid-CALC -> all outputs 0 the next cycle.
